// File: rtl/uart_rx_frame_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_frame_ctrl_pkg : shared states, defaults and helpers. Rev 1.0
// ------------------------------------------------------------------
package uart_rx_frame_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;

  localparam logic [7:0] DEF_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_CHK  = 3'd1,
    ERR_LEN  = 3'd2,
    ERR_TMO  = 3'd3,
    ERR_OVR  = 3'd4
  } err_code_e;

  function automatic int tmo_clks(input int freq, input int baud, input int nbytes);
    return nbytes * 10 * (freq / baud);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_frame_ctrl_if : byte stream, frame handshake and error bus.
// Stat signals exist only with UART_RX_FRAME_STAT_EN. Rev 1.0
// ------------------------------------------------------------------
interface uart_rx_frame_ctrl_if #(
  parameter int AW = 4
);
  logic [7:0]    rdata;
  logic          vld;
  logic          frm_vld;
  logic          frm_ack;
  logic [7:0]    frm_cmd;
  logic [7:0]    frm_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          err_chk;
  logic          err_len;
  logic          err_tmo;
  logic          err_ovr;
`ifdef UART_RX_FRAME_STAT_EN
  logic          stat_clr;
  logic [15:0]   stat_good;
  logic [15:0]   stat_err;
`endif

  modport slave (
    input  rdata, vld, frm_ack, rd_addr,
`ifdef UART_RX_FRAME_STAT_EN
    input  stat_clr,
    output stat_good, stat_err,
`endif
    output frm_vld, frm_cmd, frm_len, rd_data, busy,
    output err_chk, err_len, err_tmo, err_ovr
  );

  modport master (
    output rdata, vld, frm_ack, rd_addr,
`ifdef UART_RX_FRAME_STAT_EN
    output stat_clr,
    input  stat_good, stat_err,
`endif
    input  frm_vld, frm_cmd, frm_len, rd_data, busy,
    input  err_chk, err_len, err_tmo, err_ovr
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_frame_buf : MAX_LEN x 8 payload store, one write port, async read.
// Rev 1.0
// ------------------------------------------------------------------
module uart_frame_buf
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int AW      = addr_w(MAX_LEN)
) (
  input  wire logic          clk,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire logic [7:0]    wdata_i,
  input  wire logic [AW-1:0] raddr_i,
  output logic      [7:0]    rdata_o
);

  logic [7:0] mem_q [MAX_LEN];

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mem
    always_ff @(posedge clk) begin
      if (we_i && (waddr_i == AW'(i))) begin
        mem_q[i] <= wdata_i;
      end
    end
  end

  // Out-of-range read addresses return zero rather than aliasing.
  always_comb begin
    rdata_o = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (raddr_i == AW'(i)) begin
        rdata_o = mem_q[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_frame_ctrl : assembles/checks HEADER,CMD,LEN,PAYLOAD,CHK frames.
// Optional macro UART_RX_FRAME_STAT_EN adds saturating counters. Rev 1.0
// ------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] HEADER    = DEF_HEADER,
  parameter int         MAX_LEN   = 16,
  parameter int         FREQ      = 50_000_000,
  parameter int         BAUDRATE  = 115200,
  parameter int         TMO_BYTES = 3
) (
  input wire logic             clk,
  input wire logic             nrst,
  uart_rx_frame_ctrl_if.slave  bus
);

  localparam int               c_aw       = addr_w(MAX_LEN);
  localparam int               c_tmo      = tmo_clks(FREQ, BAUDRATE, TMO_BYTES);
  localparam int               c_tw       = $clog2(c_tmo + 1);
  localparam logic [c_tw-1:0]  c_tmo_last = c_tw'(c_tmo - 1);
  localparam logic [7:0]       c_max_len  = 8'(MAX_LEN);

  logic [2:0]      state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      idx_q, idx_d;
  logic [c_tw-1:0] tmo_q, tmo_d;
  err_code_e       err_code_q, err_code_d;

  logic            w_we;
  logic            w_active;
  logic            w_tmo_hit;
  err_code_e       w_err_code;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      len_q      <= 8'h00;
      sum_q      <= 8'h00;
      idx_q      <= 8'h00;
      tmo_q      <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    tmo_d      = '0;
    err_code_d = ERR_NONE;
    w_we       = 1'b0;
    // A pending timeout wins over a byte arriving in the same cycle.
    if (w_tmo_hit) begin
      state_d = ST_IDLE;
    end else begin
      if (w_active && !bus.vld) begin
        tmo_d = tmo_q + c_tw'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.vld && (bus.rdata == HEADER)) begin
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus.vld) begin
            cmd_d   = bus.rdata;
            sum_d   = bus.rdata;
            state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          if (bus.vld) begin
            len_d = bus.rdata;
            sum_d = sum_q + bus.rdata;
            if (bus.rdata > c_max_len) begin
              err_code_d = ERR_LEN;
              state_d    = ST_IDLE;
            end else if (bus.rdata == 8'h00) begin
              state_d = ST_CHK;
            end else begin
              idx_d   = 8'h00;
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bus.vld) begin
            w_we  = 1'b1;
            sum_d = sum_q + bus.rdata;
            if (idx_q == (len_q - 8'd1)) begin
              state_d = ST_CHK;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
        end
        ST_CHK: begin
          if (bus.vld) begin
            if (bus.rdata == sum_q) begin
              state_d = ST_HOLD;
            end else begin
              err_code_d = ERR_CHK;
              state_d    = ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (bus.vld) begin
            err_code_d = ERR_OVR;
          end
          if (bus.frm_ack) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Timeout is flagged while the counter sits at its last value; the
  // return to IDLE follows on the next clock.
  always_comb begin
    w_active   = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                 (state_q == ST_DATA) || (state_q == ST_CHK);
    w_tmo_hit  = w_active && (tmo_q == c_tmo_last);
    w_err_code = (w_tmo_hit && nrst) ? ERR_TMO : err_code_q;
  end

  assign bus.frm_vld = (state_q == ST_HOLD);
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.frm_cmd = cmd_q;
  assign bus.frm_len = len_q;
  assign bus.err_chk = (w_err_code == ERR_CHK);
  assign bus.err_len = (w_err_code == ERR_LEN);
  assign bus.err_tmo = (w_err_code == ERR_TMO);
  assign bus.err_ovr = (w_err_code == ERR_OVR);

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (c_aw)
  ) u_buf (
    .clk     (clk),
    .we_i    (w_we),
    .waddr_i (idx_q[c_aw-1:0]),
    .wdata_i (bus.rdata),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

`ifdef UART_RX_FRAME_STAT_EN
  logic [15:0] stat_good_q, stat_good_d;
  logic [15:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_good_d = stat_good_q;
    stat_err_d  = stat_err_q;
    if (bus.stat_clr) begin
      stat_good_d = 16'h0000;
      stat_err_d  = 16'h0000;
    end else begin
      if ((state_d == ST_HOLD) && (state_q == ST_CHK) && (stat_good_q != 16'hFFFF)) begin
        stat_good_d = stat_good_q + 16'd1;
      end
      if ((w_err_code != ERR_NONE) && (stat_err_q != 16'hFFFF)) begin
        stat_err_d = stat_err_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stat_good_q <= 16'h0000;
      stat_err_q  <= 16'h0000;
    end else begin
      stat_good_q <= stat_good_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign bus.stat_good = stat_good_q;
  assign bus.stat_err  = stat_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_rx_frame_ctrl : directed frames with hand-computed results.
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

  // 3 bytes * 10 bits * (50e6/115200 = 434 clk/bit)
  localparam int TMO_CLKS = 13020;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  uart_rx_frame_ctrl_if #(.AW(4)) bus ();

  uart_rx_frame_ctrl #(
    .HEADER    (8'hA5),
    .MAX_LEN   (16),
    .FREQ      (50_000_000),
    .BAUDRATE  (115200),
    .TMO_BYTES (3)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] errs();
    return {bus.err_chk, bus.err_len, bus.err_tmo, bus.err_ovr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rdata = b;
    bus.vld   = 1'b1;
    tick();
    bus.vld   = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.frm_vld, bus.busy, errs()} !== 6'b0) begin
      $display("FAIL reset_flags got=%b want=000000", {bus.frm_vld, bus.busy, errs()});
      bad++;
    end
    total++;
    if ({bus.frm_cmd, bus.frm_len} !== 16'h0000) begin
      $display("FAIL reset_cmdlen got=%h want=0000", {bus.frm_cmd, bus.frm_len});
      bad++;
    end
`ifdef UART_RX_FRAME_STAT_EN
    total++;
    if ({bus.stat_good, bus.stat_err} !== 32'h0) begin
      $display("FAIL reset_stat got=%h want=00000000", {bus.stat_good, bus.stat_err});
      bad++;
    end
`endif
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    send(8'hA5); send(8'h10); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
    total++;
    if ({bus.busy, bus.frm_vld} !== 2'b10) begin
      $display("FAIL good_pre busy,frm_vld got=%b want=10", {bus.busy, bus.frm_vld});
      bad++;
    end
    send(8'h19);  // 10+03+01+02+03
    total++;
    if ({bus.frm_vld, bus.frm_cmd, bus.frm_len, errs()} !== {1'b1, 8'h10, 8'h03, 4'b0000}) begin
      $display("FAIL good_frame got vld=%b cmd=%h len=%h err=%b want 1/10/03/0000",
               bus.frm_vld, bus.frm_cmd, bus.frm_len, errs());
      bad++;
    end
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      total++;
      if (bus.rd_data !== 8'(i + 1)) begin
        $display("FAIL good_payload[%0d] got=%h want=%h", i, bus.rd_data, 8'(i + 1));
        bad++;
      end
    end
    tick(); tick();
    total++;
    if ({bus.frm_vld, bus.frm_cmd, bus.frm_len} !== {1'b1, 8'h10, 8'h03}) begin
      $display("FAIL good_hold got vld=%b cmd=%h len=%h want 1/10/03", bus.frm_vld, bus.frm_cmd, bus.frm_len);
      bad++;
    end
    bus.frm_ack = 1'b1;
    tick();
    bus.frm_ack = 1'b0;
    total++;
    if ({bus.frm_vld, bus.busy} !== 2'b00) begin
      $display("FAIL good_ack vld,busy got=%b want=00", {bus.frm_vld, bus.busy});
      bad++;
    end
  endtask

  task automatic test_len_zero();
    send(8'hA5); send(8'h22); send(8'h00); send(8'h22);
    total++;
    if ({bus.frm_vld, bus.frm_cmd, bus.frm_len} !== {1'b1, 8'h22, 8'h00}) begin
      $display("FAIL len0 got vld=%b cmd=%h len=%h want 1/22/00", bus.frm_vld, bus.frm_cmd, bus.frm_len);
      bad++;
    end
    bus.rd_addr = 4'd0;
    #1;
    total++;
    if (bus.rd_data !== 8'h01) begin
      $display("FAIL len0_nowrite got=%h want=01", bus.rd_data);
      bad++;
    end
    bus.frm_ack = 1'b1;
    tick();
    bus.frm_ack = 1'b0;
  endtask

  task automatic test_bad_chk();
    send(8'hA5); send(8'h10); send(8'h01); send(8'hFF); send(8'h00);
    total++;
    if ({errs(), bus.frm_vld, bus.busy} !== 6'b1000_00) begin
      $display("FAIL badchk_pulse got=%b want=100000", {errs(), bus.frm_vld, bus.busy});
      bad++;
    end
    tick();
    total++;
    if (errs() !== 4'b0000) begin
      $display("FAIL badchk_width got=%b want=0000", errs());
      bad++;
    end
    send(8'hA5); send(8'h30); send(8'h02); send(8'hAA); send(8'h55); send(8'h31);
    total++;
    if ({bus.frm_vld, bus.frm_cmd, bus.frm_len} !== {1'b1, 8'h30, 8'h02}) begin
      $display("FAIL after_bad got vld=%b cmd=%h len=%h want 1/30/02", bus.frm_vld, bus.frm_cmd, bus.frm_len);
      bad++;
    end
    bus.rd_addr = 4'd1;
    #1;
    total++;
    if (bus.rd_data !== 8'h55) begin
      $display("FAIL after_bad_payload got=%h want=55", bus.rd_data);
      bad++;
    end
    bus.frm_ack = 1'b1;
    tick();
    bus.frm_ack = 1'b0;
  endtask

  task automatic test_len_garbage();
    send(8'h00);
    send(8'hFF);
    total++;
    if ({bus.busy, errs()} !== 5'b0) begin
      $display("FAIL garbage got busy,err=%b want=00000", {bus.busy, errs()});
      bad++;
    end
    send(8'hA5); send(8'h10); send(8'h11);
    total++;
    if ({errs(), bus.busy} !== 5'b0100_0) begin
      $display("FAIL len_over got err,busy=%b want=01000", {errs(), bus.busy});
      bad++;
    end
    send(8'hA5); send(8'h01); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h89);  // 01+10+(0+..+15)
    total++;
    if ({bus.frm_vld, bus.frm_len, errs()} !== {1'b1, 8'h10, 4'b0000}) begin
      $display("FAIL len_max got vld=%b len=%h err=%b want 1/10/0000", bus.frm_vld, bus.frm_len, errs());
      bad++;
    end
    bus.rd_addr = 4'd15;
    #1;
    total++;
    if (bus.rd_data !== 8'h0F) begin
      $display("FAIL len_max_last got=%h want=0f", bus.rd_data);
      bad++;
    end
    bus.frm_ack = 1'b1;
    tick();
    bus.frm_ack = 1'b0;
  endtask

  task automatic test_timeout();
    send(8'hA5);
    send(8'h10);
    repeat (TMO_CLKS - 2) tick();
    total++;
    if ({errs(), bus.busy} !== 5'b0000_1) begin
      $display("FAIL tmo_early got err,busy=%b want=00001", {errs(), bus.busy});
      bad++;
    end
    tick();
    total++;
    if ({errs(), bus.busy} !== 5'b0010_1) begin
      $display("FAIL tmo_pulse got err,busy=%b want=00101", {errs(), bus.busy});
      bad++;
    end
    tick();
    total++;
    if ({errs(), bus.busy} !== 5'b0000_0) begin
      $display("FAIL tmo_after got err,busy=%b want=00000", {errs(), bus.busy});
      bad++;
    end
  endtask

  task automatic test_overrun();
    send(8'hA5); send(8'h40); send(8'h01); send(8'h7E); send(8'hBF);
    send(8'hA5);
    total++;
    if ({errs(), bus.frm_vld, bus.frm_cmd, bus.frm_len} !== {4'b0001, 1'b1, 8'h40, 8'h01}) begin
      $display("FAIL ovr_hdr got err=%b vld=%b cmd=%h len=%h want 0001/1/40/01",
               errs(), bus.frm_vld, bus.frm_cmd, bus.frm_len);
      bad++;
    end
    send(8'h00);
    bus.rd_addr = 4'd0;
    #1;
    total++;
    if ({errs(), bus.rd_data} !== {4'b0001, 8'h7E}) begin
      $display("FAIL ovr_keep got err=%b data=%h want 0001/7e", errs(), bus.rd_data);
      bad++;
    end
    bus.frm_ack = 1'b1;
    send(8'h33);
    bus.frm_ack = 1'b0;
    total++;
    if ({errs(), bus.frm_vld, bus.busy} !== 6'b0001_00) begin
      $display("FAIL ovr_ack got err,vld,busy=%b want=000100", {errs(), bus.frm_vld, bus.busy});
      bad++;
    end
  endtask

`ifdef UART_RX_FRAME_STAT_EN
  task automatic test_stat();
    total++;
    if ({bus.stat_good, bus.stat_err} !== {16'd5, 16'd6}) begin
      $display("FAIL stat_count got good=%0d err=%0d want 5/6", bus.stat_good, bus.stat_err);
      bad++;
    end
    bus.stat_clr = 1'b1;
    tick();
    bus.stat_clr = 1'b0;
    total++;
    if ({bus.stat_good, bus.stat_err} !== 32'h0) begin
      $display("FAIL stat_clr got good=%0d err=%0d want 0/0", bus.stat_good, bus.stat_err);
      bad++;
    end
    send(8'hA5); send(8'h60); send(8'h00);
    bus.stat_clr = 1'b1;
    send(8'h60);
    bus.stat_clr = 1'b0;
    total++;
    if ({bus.frm_vld, bus.stat_good} !== {1'b1, 16'd0}) begin
      $display("FAIL stat_clr_prio got vld=%b good=%0d want 1/0", bus.frm_vld, bus.stat_good);
      bad++;
    end
    bus.frm_ack = 1'b1;
    tick();
    bus.frm_ack = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    send(8'hA5); send(8'h50); send(8'h04); send(8'h01); send(8'h02);
    nrst      = 1'b0;
    bus.rdata = 8'h03;
    bus.vld   = 1'b1;
    tick();
    bus.vld   = 1'b0;
    total++;
    if ({errs(), bus.busy} !== 5'b0) begin
      $display("FAIL rst_mid got err,busy=%b want=00000", {errs(), bus.busy});
      bad++;
    end
    tick();
    nrst = 1'b1;
    send(8'h03);
    send(8'h04);
    total++;
    if ({errs(), bus.busy, bus.frm_vld} !== 6'b0) begin
      $display("FAIL rst_mid_after got err,busy,vld=%b want=000000", {errs(), bus.busy, bus.frm_vld});
      bad++;
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    nrst        = 1'b0;
    bus.rdata   = 8'h00;
    bus.vld     = 1'b0;
    bus.frm_ack = 1'b0;
    bus.rd_addr = 4'd0;
`ifdef UART_RX_FRAME_STAT_EN
    bus.stat_clr = 1'b0;
`endif
    test_reset();
    test_good_frame();
    test_len_zero();
    test_bad_chk();
    test_len_garbage();
    test_timeout();
    test_overrun();
`ifdef UART_RX_FRAME_STAT_EN
    test_stat();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
